// File: rtl/psram_mem_ctrl_if.sv
// rtl/psram_mem_ctrl_if.sv - core data-port and PSRAM strobe/busy signal bundle for psram_mem_ctrl
interface psram_mem_ctrl_if #(
    parameter int ADDR_BITS = 23
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [31:0]          cpu_addr;
    logic [3:0]           cpu_be;
    logic [31:0]          cpu_wdata;
    logic                 cpu_stall;
    logic                 cpu_done;
    logic [31:0]          cpu_rdata;
    logic                 cpu_err;
    logic [ADDR_BITS-2:0] mem_addr;
    logic [15:0]          mem_wdata;
    logic                 mem_wr_hi;
    logic                 mem_wr_lo;
    logic                 mem_write_en;
    logic                 mem_read_en;
    logic                 mem_busy;
    logic                 mem_read_avail;
    logic [15:0]          mem_rdata;

    // the controller: serves the core, drives the PSRAM port
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        input  mem_busy, mem_read_avail, mem_rdata,
        output cpu_stall, cpu_done, cpu_rdata, cpu_err,
        output mem_addr, mem_wdata, mem_wr_hi, mem_wr_lo, mem_write_en, mem_read_en
    );

    // the surroundings: core request side plus PSRAM response side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        output mem_busy, mem_read_avail, mem_rdata,
        input  cpu_stall, cpu_done, cpu_rdata, cpu_err,
        input  mem_addr, mem_wdata, mem_wr_hi, mem_wr_lo, mem_write_en, mem_read_en
    );
endinterface

// File: rtl/psram_mem_ctrl.sv
// rtl/psram_mem_ctrl.sv - splits 32-bit core accesses into 16-bit PSRAM transactions; MEMCTRL_TIMEOUT_EN adds WAIT abort
module psram_mem_ctrl #(
    parameter int ADDR_BITS = 23,
    parameter int TIMEOUT   = 1023
) (
    input  logic            clk,
    input  logic            reset_n,
    psram_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-3:0] addr_q;
    logic                 we_q;
    logic [3:0]           be_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q;
    logic                 first_q;
    logic                 accept;
    logic                 strobe;
    logic                 is_hi;
    logic                 active;
    logic                 wait_done;
    logic                 timeout_hit;
    logic                 unused_addr_bits;

    assign accept    = (state_q == IDLE) && bus.cpu_req;
    assign is_hi     = (state_q == ISSUE_HI) || (state_q == WAIT_HI);
    assign active    = (state_q != IDLE) && (state_q != DONE);
    // a write may still see the busy flag of its own strobe in the first WAIT cycle
    assign wait_done = we_q ? (!first_q && !bus.mem_busy) : bus.mem_read_avail;
    assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_BITS], bus.cpu_addr[1:0]};

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
    logic             in_wait;

    assign in_wait     = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    assign timeout_hit = in_wait && (wait_cnt_q == CNT_LAST);
    assign bus.cpu_err = err_q;

    // count cycles spent in the current WAIT state and flag an aborted access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (strobe)
                wait_cnt_q <= '0;
            else if (in_wait)
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (accept)
                err_q <= 1'b0;
            else if (timeout_hit && !wait_done)
                err_q <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign bus.cpu_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // next state and the one-cycle PSRAM strobe
    always_comb begin
        state_d = state_q;
        strobe  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (|bus.cpu_be[1:0])
                        state_d = ISSUE_LO;
                    else if (|bus.cpu_be[3:2])
                        state_d = ISSUE_HI;
                    else
                        state_d = DONE;
                end
            end
            ISSUE_LO: begin
                if (!bus.mem_busy) begin
                    strobe  = 1'b1;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (wait_done)
                    state_d = (|be_q[3:2]) ? ISSUE_HI : DONE;
                else if (timeout_hit)
                    state_d = DONE;
            end
            ISSUE_HI: begin
                if (!bus.mem_busy) begin
                    strobe  = 1'b1;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (wait_done || timeout_hit)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // latch the request, assemble read lanes, track the first WAIT cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= '0;
            rdata_q <= '0;
            first_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.cpu_addr[ADDR_BITS-1:2];
                we_q    <= bus.cpu_we;
                be_q    <= bus.cpu_be;
                wdata_q <= bus.cpu_wdata;
                rdata_q <= '0;
            end else if (!we_q && bus.mem_read_avail) begin
                if (state_q == WAIT_LO)
                    rdata_q[15:0]  <= bus.mem_rdata & {{8{be_q[1]}}, {8{be_q[0]}}};
                if (state_q == WAIT_HI)
                    rdata_q[31:16] <= bus.mem_rdata & {{8{be_q[3]}}, {8{be_q[2]}}};
            end
            first_q <= strobe;
        end
    end

    assign bus.mem_addr     = {addr_q, is_hi};
    assign bus.mem_wdata    = is_hi ? wdata_q[31:16] : wdata_q[15:0];
    assign bus.mem_wr_lo    = active && we_q && (is_hi ? be_q[2] : be_q[0]);
    assign bus.mem_wr_hi    = active && we_q && (is_hi ? be_q[3] : be_q[1]);
    assign bus.mem_write_en = strobe && we_q;
    assign bus.mem_read_en  = strobe && !we_q;
    assign bus.cpu_stall    = active || accept;
    assign bus.cpu_done     = (state_q == DONE);
    assign bus.cpu_rdata    = rdata_q;
endmodule

// File: tb/tb_psram_mem_ctrl.sv
// tb/tb_psram_mem_ctrl.sv - directed bench for psram_mem_ctrl with transaction-level model and PSRAM responder
module tb_psram_mem_ctrl;
    localparam int AB = 23;

    logic clk = 1'b0;
    logic reset_n;

    psram_mem_ctrl_if #(.ADDR_BITS(AB)) bus ();

    psram_mem_ctrl #(.ADDR_BITS(AB), .TIMEOUT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          haddr;
        bit          we;
        logic [15:0] wd;
        bit          hi;
        bit          lo;
    } op_t;

    op_t         ops[$];
    logic [15:0] mem [int];
    int          strobe_log[$];
    int          n_rd, n_wr, n_done;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] last_rdata;
    logic        last_err;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 0;
    int          pre_busy = 0;
    bit          hang     = 0;
    bit          stray    = 0;

    function automatic logic [15:0] mrd(input int a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // PSRAM responder: busy for lat cycles after a strobe, read data at the end of it
    initial begin
        bit          s_rd, s_wr, s_hi, s_lo, rd_pend;
        int          s_a, rd_a, rd_cnt, wr_cnt;
        logic [15:0] s_wd, t;
        rd_pend = 0; rd_cnt = 0; wr_cnt = 0; rd_a = 0;
        bus.mem_busy = 1'b0; bus.mem_read_avail = 1'b0; bus.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            s_rd = bus.mem_read_en;  s_wr = bus.mem_write_en;
            s_hi = bus.mem_wr_hi;    s_lo = bus.mem_wr_lo;
            s_a  = int'(bus.mem_addr); s_wd = bus.mem_wdata;
            @(posedge clk); #1;
            bus.mem_busy = 1'b0; bus.mem_read_avail = 1'b0;
            if (pre_busy > 0) begin bus.mem_busy = 1'b1; pre_busy--; end
            if (s_rd && !hang) begin rd_pend = 1; rd_cnt = lat; rd_a = s_a; end
            if (s_wr) begin
                t = mrd(s_a);
                if (s_lo) t[7:0]  = s_wd[7:0];
                if (s_hi) t[15:8] = s_wd[15:8];
                mem[s_a] = t;
                wr_cnt = lat;
            end
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    bus.mem_read_avail = 1'b1; bus.mem_rdata = mrd(rd_a); rd_pend = 0;
                end else begin
                    bus.mem_busy = 1'b1; rd_cnt--;
                end
            end
            if (wr_cnt > 0) begin bus.mem_busy = 1'b1; wr_cnt--; end
            if (stray) begin bus.mem_read_avail = 1'b1; bus.mem_rdata = 16'hDEAD; stray = 0; end
        end
    end

    // per-cycle compare against the transaction model
    initial begin
        op_t o;
        forever begin
            @(negedge clk);
            chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !bus.cpu_done));
            if (bus.mem_read_en || bus.mem_write_en) begin
                n_rd += int'(bus.mem_read_en);
                n_wr += int'(bus.mem_write_en);
                strobe_log.push_back(int'(bus.mem_addr));
                chk("strobe_while_busy", 32'(bus.mem_busy), 0);
                chk("both_strobes", 32'(bus.mem_read_en && bus.mem_write_en), 0);
                chk("op_expected", 32'(ops.size() != 0), 1);
                if (ops.size() != 0) begin
                    o = ops.pop_front();
                    chk("op_haddr", 32'(bus.mem_addr), 32'(o.haddr));
                    chk("op_kind", 32'(bus.mem_write_en), 32'(o.we));
                    if (o.we) begin
                        chk("op_wdata", 32'(bus.mem_wdata), 32'(o.wd));
                        chk("op_wr_hi", 32'(bus.mem_wr_hi), 32'(o.hi));
                        chk("op_wr_lo", 32'(bus.mem_wr_lo), 32'(o.lo));
                    end
                end
            end
            if (bus.cpu_done) begin
                n_done++;
                chk("done_rdata", bus.cpu_rdata, exp_rdata);
                chk("done_err", 32'(bus.cpu_err), 32'(exp_err));
                chk("done_ops_left", 32'(ops.size()), 0);
            end
        end
    end

    task automatic setup_req(input bit we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd);
        int          base;
        op_t         o;
        logic [15:0] t;
        base = int'(addr[AB-1:2]) * 2;
        exp_rdata = '0;
        exp_err   = hang;
        for (int h = 0; h < 2; h++) begin
            if (be[2*h +: 2] != 2'b00) begin
                o.haddr = base + h; o.we = we; o.wd = wd[16*h +: 16];
                o.hi = be[2*h+1]; o.lo = be[2*h];
                ops.push_back(o);
                t = mrd(base + h);
                for (int b = 0; b < 2; b++)
                    if (!we && !hang && be[2*h+b]) exp_rdata[16*h+8*b +: 8] = t[8*b +: 8];
            end
        end
        strobe_log.delete(); n_rd = 0; n_wr = 0; n_done = 0;
        bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_be = be; bus.cpu_wdata = wd;
        bus.cpu_req = 1'b1;
    endtask

    task automatic run_req(input bit we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int max_cyc, output int cyc, output bit got);
        setup_req(we, addr, be, wd);
        cyc = 0; got = 0;
        while (!got && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (bus.cpu_done) begin got = 1; last_rdata = bus.cpu_rdata; last_err = bus.cpu_err; end
        end
        @(posedge clk); #2;
        if (got) bus.cpu_req = 1'b0;
    endtask

    task automatic finish_req(input string name, input bit got, input int cyc, input int exp_cyc,
                              input logic [31:0] exp_rd);
        chk({name, "_done"}, 32'(got), 1);
        chk({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_rdata"}, last_rdata, exp_rd);
        repeat (2) @(negedge clk);
        chk({name, "_done_pulses"}, 32'(n_done), 1);
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; bus.cpu_req = 1'b0; ops.delete();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int cyc;
        reset_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_be = 4'h0; bus.cpu_wdata = '0;
        mem[32'h80] = 16'h1234;
        mem[32'h81] = 16'hABCD;
        @(negedge clk);
        chk("rst_stall", 32'(bus.cpu_stall), 0);
        chk("rst_done", 32'(bus.cpu_done), 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_err", 32'(bus.cpu_err), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_strobes", 32'({bus.mem_read_en, bus.mem_write_en, bus.mem_wr_hi, bus.mem_wr_lo}), 0);
        @(posedge clk); #2;
        reset_n = 1'b1;

        // word load, zero-wait memory
        lat = 0;
        run_req(0, 32'h0000_0100, 4'hF, 32'h0, 40, cyc, got);
        chk("t1_reads", 32'(n_rd), 2);
        if (strobe_log.size() >= 2) begin
            chk("t1_first_addr", 32'(strobe_log[0]), 32'h80);
            chk("t1_second_addr", 32'(strobe_log[1]), 32'h81);
        end
        finish_req("t1", got, cyc, 6, 32'hABCD_1234);

        // byte store in the upper half only
        lat = 1;
        run_req(1, 32'h0000_0202, 4'b0100, 32'h00EE_0000, 40, cyc, got);
        chk("t2_writes", 32'(n_wr), 1);
        chk("t2_reads", 32'(n_rd), 0);
        if (strobe_log.size() >= 1) chk("t2_addr", 32'(strobe_log[0]), 32'h101);
        finish_req("t2", got, cyc, 5, 32'h0);
        chk("t2_mem", 32'(mrd(32'h101)), 32'h00EE);

        // halfword load behind 5 busy cycles
        lat = 0;
        pre_busy = 5;
        run_req(0, 32'h0000_0100, 4'b0011, 32'h0, 40, cyc, got);
        chk("t3_reads", 32'(n_rd), 1);
        finish_req("t3", got, cyc, 9, 32'h0000_1234);

        // empty byte-enable request
        run_req(0, 32'h0000_0100, 4'h0, 32'h0, 40, cyc, got);
        chk("t4_strobes", 32'(n_rd + n_wr), 0);
        finish_req("t4", got, cyc, 2, 32'h0);

        // word store with a slow memory, then read it back partially
        lat = 2;
        run_req(1, 32'h0000_0300, 4'hF, 32'hCAFE_BABE, 40, cyc, got);
        chk("t5_writes", 32'(n_wr), 2);
        finish_req("t5", got, cyc, 10, 32'h0);
        chk("t5_mem_lo", 32'(mrd(32'h180)), 32'hBABE);
        chk("t5_mem_hi", 32'(mrd(32'h181)), 32'hCAFE);
        lat = 0;
        run_req(0, 32'h0000_0300, 4'b1010, 32'h0, 40, cyc, got);
        finish_req("t6", got, cyc, 6, 32'hCA00_BA00);

        // reset during WAIT_HI of a word load, then stray read_avail pulses
        lat = 3;
        setup_req(0, 32'h0000_0100, 4'hF, 32'h0);
        cyc = 0;
        while (n_rd < 2 && cyc < 40) begin @(negedge clk); cyc++; end
        chk("t7_reached_wait_hi", 32'(n_rd), 2);
        @(posedge clk); #2;
        reset_n = 1'b0; bus.cpu_req = 1'b0; ops.delete();
        @(negedge clk);
        chk("t7_rst_stall", 32'(bus.cpu_stall), 0);
        chk("t7_rst_done", 32'(bus.cpu_done), 0);
        chk("t7_rst_rdata", bus.cpu_rdata, 0);
        chk("t7_rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("t7_rst_read_en", 32'(bus.mem_read_en), 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        stray = 1;
        repeat (6) begin
            @(negedge clk);
            chk("t7_idle_done", 32'(bus.cpu_done), 0);
            chk("t7_idle_rdata", bus.cpu_rdata, 0);
        end
        @(posedge clk); #2;
        lat = 0;
        run_req(0, 32'h0000_0100, 4'hF, 32'h0, 40, cyc, got);
        finish_req("t7_after", got, cyc, 6, 32'hABCD_1234);

        // read whose data never returns
        hang = 1;
        run_req(0, 32'h0000_0100, 4'b0011, 32'h0, 30, cyc, got);
`ifdef MEMCTRL_TIMEOUT_EN
        chk("t8_err", 32'(last_err), 1);
        finish_req("t8", got, cyc, 11, 32'h0);
        hang = 0;
`else
        chk("t8_no_done", 32'(got), 0);
        chk("t8_stall_held", 32'(bus.cpu_stall), 1);
        hang = 0;
        do_reset();
`endif

        // upper halfword load after recovery
        run_req(0, 32'h0000_0100, 4'b1100, 32'h0, 40, cyc, got);
        finish_req("t9", got, cyc, 4, 32'hABCD_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
